// File: rtl/artemis_clk_pkg.sv
// artemis_clk_pkg: shared state encoding and default timing constants for the clock supervisor
package artemis_clk_pkg;
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT   = 65535;
  localparam int DEF_MAX_RETRIES    = 7;
  function automatic int cnt_w(input int n);
    return n < 1 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/artemis_sync2.sv
// artemis_sync2: two-flop synchronizer for a single asynchronous level
module artemis_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= 2'b00;
    else        {q, s1} <= {s1, d};
endmodule

// File: rtl/artemis_clk_supervisor.sv
// artemis_clk_supervisor: PLL reset sequencing, lock qualification, retry/timeout and system reset release
module artemis_clk_supervisor
  import artemis_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] lock_lost_count,
  output logic [2:0] state
);
  localparam int RW = cnt_w(PLL_RST_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int YW = cnt_w(MAX_RETRIES);
  state_t st, nxt;
  logic locked_s, entry, lost;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] stb_cnt;
  logic [YW-1:0] retry_cnt;
  artemis_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));
  assign state = st;
  always_comb begin
    nxt = st;
    unique case (st)
      ST_PLL_RST:   nxt = rst_cnt == RW'(PLL_RST_CYCLES - 1) ? ST_WAIT_LOCK : ST_PLL_RST;
      ST_WAIT_LOCK: nxt = locked_s ? ST_STABLE
                        : to_cnt != TW'(LOCK_TIMEOUT - 1) ? ST_WAIT_LOCK
                        : retry_cnt == YW'(MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
      ST_STABLE:    nxt = !locked_s ? ST_WAIT_LOCK
                        : stb_cnt == SW'(STABLE_CYCLES - 1) ? ST_RUN : ST_STABLE;
      ST_RUN:       nxt = (!locked_s || soft_rst_req) ? ST_PLL_RST : ST_RUN;
      ST_FAIL:      nxt = ST_FAIL;
      default:      nxt = ST_PLL_RST;
    endcase
    entry = nxt != st;
    lost  = st == ST_RUN && !locked_s;
  end
  // Outputs are registered from the next state so they change in the first cycle of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= ST_PLL_RST;
      rst_cnt         <= '0;
      to_cnt          <= '0;
      stb_cnt         <= '0;
      retry_cnt       <= '0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      timeout_err     <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      st              <= nxt;
      rst_cnt         <= (entry || st != ST_PLL_RST) ? '0 : rst_cnt + 1'b1;
      to_cnt          <= (entry || st != ST_WAIT_LOCK) ? '0 : to_cnt + 1'b1;
      stb_cnt         <= (entry || st != ST_STABLE) ? '0 : stb_cnt + 1'b1;
      retry_cnt       <= st == ST_RUN ? '0
                       : (st == ST_WAIT_LOCK && nxt == ST_PLL_RST) ? retry_cnt + 1'b1 : retry_cnt;
      pll_rst         <= nxt == ST_PLL_RST || nxt == ST_FAIL;
      sys_rst         <= nxt != ST_RUN;
      ready           <= nxt == ST_RUN;
      timeout_err     <= timeout_err || nxt == ST_FAIL;
      lock_lost_count <= (lost && lock_lost_count != 8'hFF) ? lock_lost_count + 8'd1 : lock_lost_count;
    end
  end
endmodule

// File: tb/tb_artemis_clk_supervisor.sv
// tb_artemis_clk_supervisor: scoreboard-driven scenario bench for the clock supervisor
module tb_artemis_clk_supervisor;
  localparam int PR = 4, SC = 8, LT = 20, MR = 2;
  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, soft_rst_req = 1'b0;
  logic pll_rst, sys_rst, ready, timeout_err;
  logic [7:0] lock_lost_count;
  logic [2:0] state;
  typedef struct {string name; int val;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  artemis_clk_supervisor #(.PLL_RST_CYCLES(PR), .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .timeout_err(timeout_err),
    .lock_lost_count(lock_lost_count), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      e.name = "empty_queue";
      e.val  = -1;
    end else e = exp_q.pop_front();
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_count(output int n);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 500);
  endtask

  task automatic wait_state(input logic [2:0] s, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state !== s && n < 500);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d required 0", state); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst: got %b required 1", pll_rst); end
    n_cmp++; if (sys_rst !== 1'b1) begin n_bad++; $display("FAIL reset_sys_rst: got %b required 1", sys_rst); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b required 0", ready); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b required 0", timeout_err); end
    n_cmp++; if (lock_lost_count !== 8'd0) begin n_bad++; $display("FAIL reset_llc: got %0d required 0", lock_lost_count); end
  endtask

  task automatic test_lock_seq();
    int n;
    exp_t e;
    exp_q.push_back('{"pll_rst_cycles", PR});
    release_count(n);
    e = pop();
    n_cmp++; if (n !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, n, e.val); end
    repeat (10 - PR) @(negedge clk);
    pll_locked = 1'b1;
    exp_q.push_back('{"ready_latency", 2 + SC + 1});
    wait_ready(n);
    e = pop();
    n_cmp++; if (n !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, n, e.val); end
    n_cmp++; if (sys_rst !== 1'b0) begin n_bad++; $display("FAIL run_sys_rst: got %b required 0", sys_rst); end
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL run_state: got %0d required 3", state); end
  endtask

  task automatic test_glitch();
    int n;
    bit saw;
    exp_t e;
    do_reset();
    release_count(n);
    repeat (6) @(negedge clk);
    pll_locked = 1'b1;
    wait_state(3'd2, n);
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (state == 3'd1) saw = 1;
    end
    pll_locked = 1'b1;
    exp_q.push_back('{"glitch_ready_latency", 2 + SC + 1});
    wait_ready(n);
    e = pop();
    n_cmp++; if (n !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, n, e.val); end
    n_cmp++; if (saw !== 1'b1) begin n_bad++; $display("FAIL glitch_wait_lock: got %b required 1", saw); end
    n_cmp++; if (lock_lost_count !== 8'd0) begin n_bad++; $display("FAIL glitch_llc: got %0d required 0", lock_lost_count); end
  endtask

  task automatic test_timeout();
    int n, falls;
    logic prev;
    exp_t e;
    do_reset();
    release_count(n);
    repeat (40) @(negedge clk);
    do_reset();
    exp_q.push_back('{"fail_latency", (PR + LT) * (MR + 1)});
    exp_q.push_back('{"pll_rst_pulses", MR + 1});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    falls = 0;
    prev = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
    end while (state !== 3'd4 && n < 1000);
    e = pop();
    n_cmp++; if (n !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, n, e.val); end
    e = pop();
    n_cmp++; if (falls !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, falls, e.val); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL fail_timeout_err: got %b required 1", timeout_err); end
    n_cmp++; if ({pll_rst, sys_rst, ready} !== 3'b110) begin n_bad++; $display("FAIL fail_outputs: got %b required 110", {pll_rst, sys_rst, ready}); end
    pll_locked = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL fail_sticky_state: got %0d required 4", state); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL fail_sticky_err: got %b required 1", timeout_err); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL fail_cleared_err: got %b required 0", timeout_err); end
  endtask

  task automatic test_saturate();
    int n, exp_cnt;
    exp_t e;
    do_reset();
    release_count(n);
    pll_locked = 1'b1;
    wait_ready(n);
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pll_locked = 1'b0;
      exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
      exp_q.push_back('{"sat_llc", exp_cnt});
      wait_state(3'd0, n);
      e = pop();
      n_cmp++; if (int'(lock_lost_count) !== e.val) begin n_bad++; $display("FAIL %s[%0d]: got %0d required %0d", e.name, i, lock_lost_count, e.val); end
      pll_locked = 1'b1;
      wait_ready(n);
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL sat_resequence[%0d]: got ready=%b required 1", i, ready); end
    end
    n_cmp++; if (lock_lost_count !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d required 255", lock_lost_count); end
  endtask

  task automatic test_soft();
    int n, ent;
    logic [2:0] prev;
    exp_t e;
    do_reset();
    release_count(n);
    pll_locked = 1'b1;
    wait_ready(n);
    exp_q.push_back('{"soft_only_llc", 0});
    @(negedge clk);
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL soft_only_state: got %0d required 0", state); end
    e = pop();
    n_cmp++; if (int'(lock_lost_count) !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, lock_lost_count, e.val); end
    wait_ready(n);
    exp_q.push_back('{"sim_entries", 1});
    exp_q.push_back('{"sim_llc", 1});
    @(negedge clk);
    pll_locked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    soft_rst_req = 1'b1;
    ent = 0;
    prev = state;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      soft_rst_req = 1'b0;
      if (state == 3'd0 && prev != 3'd0) ent++;
      prev = state;
    end
    e = pop();
    n_cmp++; if (ent !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, ent, e.val); end
    e = pop();
    n_cmp++; if (int'(lock_lost_count) !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, lock_lost_count, e.val); end
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL soft_ignored_wait: got %0d required 1", state); end
  endtask

  task automatic test_async_reset();
    int n;
    exp_t e;
    pll_locked = 1'b1;
    wait_state(3'd2, n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL async_state: got %0d required 0", state); end
    n_cmp++; if ({pll_rst, sys_rst, ready, timeout_err} !== 4'b1100) begin n_bad++; $display("FAIL async_outputs: got %b required 1100", {pll_rst, sys_rst, ready, timeout_err}); end
    n_cmp++; if (lock_lost_count !== 8'd0) begin n_bad++; $display("FAIL async_llc: got %0d required 0", lock_lost_count); end
    pll_locked = 1'b0;
    exp_q.push_back('{"post_async_pll_rst_cycles", PR});
    release_count(n);
    e = pop();
    n_cmp++; if (n !== e.val) begin n_bad++; $display("FAIL %s: got %0d required %0d", e.name, n, e.val); end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_glitch();
    test_timeout();
    test_saturate();
    test_soft();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/artemis_clk_supervisor.md
ARTEMIS_CLK_SUPERVISOR -- requirements
Module: artemis_clk_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held high per sequence.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, maximum cycles waiting for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 7, lock-timeout retries allowed before fail.
REQ-005 SHALL have port clk  input  1  sole clock, free-running reference from the board IBUFG.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port pll_locked  input  1  PLL LOCKED, asynchronous to clk.
REQ-008 SHALL have port soft_rst_req  input  1  single-cycle pulse requesting full re-sequence.
REQ-009 SHALL have port pll_rst  output  1  active-high reset to PLL RST.
REQ-010 SHALL have port sys_rst  output  1  active-high synchronous reset for downstream logic.
REQ-011 SHALL have port ready  output  1  high only in RUN.
REQ-012 SHALL have port timeout_err  output  1  sticky; set on entry to FAIL.
REQ-013 SHALL have port lock_lost_count  output  8  saturating count of lock losses in RUN.
REQ-014 SHALL have port state  output  3  current state encoding, for debug.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer; all decisions use the synchronized value locked_s (2-cycle latency).
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL, encoded 0..4.
REQ-017 PLL_RST: pll_rst=1, sys_rst=1; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, sys_rst=1; locked_s=1 -> STABLE; timeout counter reaching LOCK_TIMEOUT with locked_s=0 -> retry_cnt+1 and PLL_RST, or FAIL if retry_cnt already equals MAX_RETRIES.
REQ-019 STABLE: stable counter increments each cycle locked_s=1; locked_s=0 -> WAIT_LOCK with timeout counter cleared; count reaching STABLE_CYCLES -> RUN.
REQ-020 RUN: sys_rst=0, ready=1, retry_cnt cleared; locked_s=0 -> lock_lost_count+1 (saturate at 255) and PLL_RST.
REQ-021 RUN with soft_rst_req=1 -> PLL_RST without incrementing lock_lost_count; soft_rst_req ignored in all other states.
REQ-022 Simultaneous locked_s fall and soft_rst_req in RUN -> lock_lost_count increments once, single transition to PLL_RST.
REQ-023 FAIL: pll_rst=1, sys_rst=1, ready=0, timeout_err=1; remains until rst_n asserted.
REQ-024 All outputs SHALL be registered; pll_rst, sys_rst, ready change in the first cycle of the new state.
REQ-025 Counters SHALL be sized with clog2 of their parameter+1 and cleared on every state entry.
REQ-026 ready SHALL assert exactly 2+STABLE_CYCLES+1 cycles after a clean pll_locked rise in WAIT_LOCK (sync, count, transition).

Reset
REQ-027 While rst_n=0: state=PLL_RST, pll_rst=1, sys_rst=1, ready=0, timeout_err=0, lock_lost_count=0, retry_cnt=0, synchronizer flops=0, all counters 0.
REQ-028 Reset assertion SHALL act asynchronously; deassertion SHALL take effect at the next clk edge, starting a fresh PLL_RST sequence.
REQ-029 rst_n assertion mid-sequence (any state) SHALL abandon it with no residual count or retry carry-over.

Structure
REQ-030 State encoding and default parameter constants SHALL reside in shared package artemis_clk_pkg.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module artemis_sync2, reusable elsewhere.
REQ-032 Implementation SHALL contain no vendor primitives; it is pure RTL alongside artemis_clkgen.

Verification (PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=20, MAX_RETRIES=2)
REQ-033 Release rst_n, raise pll_locked 10 cycles later -> pll_rst high 4 cycles, ready rises exactly 11 cycles after pll_locked rise, sys_rst falls same cycle.
REQ-034 pll_locked glitch low 3 cycles during STABLE -> return to WAIT_LOCK, stable count restarts, ready delayed accordingly, lock_lost_count stays 0.
REQ-035 pll_locked held 0 -> three 20-cycle timeouts, pll_rst pulsed 3 times, then state=4, timeout_err=1 sticky until rst_n.
REQ-036 In RUN drop pll_locked 300 times -> lock_lost_count saturates at 255, re-sequence each time.
REQ-037 In RUN assert soft_rst_req same cycle locked_s falls -> lock_lost_count +1 only, one PLL_RST entry; soft_rst_req alone -> count unchanged.
REQ-038 Assert rst_n mid-STABLE -> all outputs at reset values immediately (asynchronously, without waiting for a clk edge).
